// File: rtl/multi_cycle_core.sv
// multi_cycle_core: RV32I-subset core that executes each instruction over a
// FETCH / DECODE / EXEC / MEM / WB state sequence. Instructions and data share
// one req/ready memory port, so memory of any latency can be attached.
// Illegal encodings, ecall, out-of-range register indices and misaligned
// targets or addresses all end in a sticky HALT state.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic        halted,
    output logic [31:0] pc_dbg
);
    localparam int RW = (NUM_REGS > 16) ? 5 : 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, oldpc, ir, a, b, imm, aluout, mdr, addr;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        is_load, is_store, is_reg, is_imm, is_branch, is_jal;
    logic        alu_f3_ok, legal, bad_reg, br_taken;
    logic [31:0] imm_dec, rs1_val, rs2_val, addr_calc, target;
    logic        rf_we;
    logic [31:0] rf_wdata;

    // add / sub / and / or / signed slt selected by funct3 (sub only for R-type)
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub,
                                        input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        case (f3)
            3'b111:  alu = x & y;
            3'b110:  alu = x | y;
            3'b010:  alu = {31'd0, (sx < sy)};
            default: alu = sub ? (x - y) : (x + y);
        endcase
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                       (funct3 == 3'b110) || (funct3 == 3'b010);
    assign is_load   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    assign is_store  = (opcode == OP_STORE) && (funct3 == 3'b010);
    assign is_reg    = (opcode == OP_REG) &&
                       (((funct7 == 7'b0000000) && alu_f3_ok) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign is_imm    = (opcode == OP_IMM) && alu_f3_ok;
    assign is_branch = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
    assign is_jal    = (opcode == OP_JAL);
    assign legal     = is_load | is_store | is_reg | is_imm | is_branch | is_jal;

    // Only the register fields an instruction actually uses are range-checked.
    assign bad_reg = ((is_load | is_store | is_reg | is_imm | is_branch) && (int'(rs1) >= NUM_REGS)) ||
                     ((is_store | is_reg | is_branch) && (int'(rs2) >= NUM_REGS)) ||
                     ((is_load | is_reg | is_imm | is_jal) && (int'(rd) >= NUM_REGS));

    assign addr_calc = a + imm;
    assign target    = oldpc + imm;
    assign br_taken  = is_branch && ((a == b) ^ funct3[0]);
    assign halted    = (state == S_HALT);
    assign pc_dbg    = pc;

    // Immediate decode by format and register-file read with x0 forced to zero
    always_comb begin
        case (opcode)
            OP_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:   imm_dec = {{20{ir[31]}}, ir[31:20]};
        endcase
        rs1_val = '0;
        rs2_val = '0;
        if ((rs1 != 5'd0) && (int'(rs1) < NUM_REGS)) rs1_val = regs[rs1[RW-1:0]];
        if ((rs2 != 5'd0) && (int'(rs2) < NUM_REGS)) rs2_val = regs[rs2[RW-1:0]];
    end

    // Next-state, memory port, retire pulse and register write-port control
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {pc[31:2], 2'b00};
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = (!legal || bad_reg) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_nx = (addr_calc[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (is_branch) begin
                    if (br_taken && (target[1:0] != 2'b00)) begin
                        state_nx = S_HALT;
                    end else begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                end else if (is_jal) begin
                    if (target[1:0] != 2'b00) begin
                        state_nx = S_HALT;
                    end else begin
                        retire   = 1'b1;
                        rf_we    = 1'b1;
                        rf_wdata = oldpc + 32'd4;
                        state_nx = S_FETCH;
                    end
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = {addr[31:2], 2'b00};
                if (is_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = b;
                end
                if (mem_ready) begin
                    if (is_store) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                retire   = 1'b1;
                rf_we    = 1'b1;
                rf_wdata = is_load ? mdr : aluout;
                state_nx = S_FETCH;
            end
            default: state_nx = S_HALT;
        endcase
        // Reset abandons any transaction immediately and suppresses side effects.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            retire    = 1'b0;
            rf_we     = 1'b0;
        end
    end

    // State register and program counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            if ((state == S_FETCH) && mem_ready) begin
                pc <= pc + 32'd4;
            end else if ((state == S_EXEC) && (state_nx == S_FETCH) && (is_jal || br_taken)) begin
                pc <= target;
            end
        end
    end

    // Datapath latches: IR/OLDPC on fetch, operands on decode, results on exec/mem
    always_ff @(posedge clk) begin
        if ((state == S_FETCH) && mem_ready) begin
            ir    <= mem_rdata;
            oldpc <= pc;
        end
        if (state == S_DECODE) begin
            a   <= rs1_val;
            b   <= rs2_val;
            imm <= imm_dec;
        end
        if (state == S_EXEC) begin
            aluout <= alu(funct3, is_reg & funct7[5], a, is_reg ? b : imm);
            addr   <= addr_calc;
        end
        if ((state == S_MEM) && mem_ready) mdr <= mem_rdata;
    end

    // Register file: cleared on reset, writes to x0 dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rf_we && (rd != 5'd0)) begin
            regs[rd[RW-1:0]] <= rf_wdata;
        end
    end
endmodule
